interrupt_ack_sequencer: RTL
============================

Name: interrupt_ack_sequencer

Overview:
- Sequences the two-pulse 8086-mode INTA cycle for the 8259A core. It sits directly downstream of the priority resolver and cascade stage.
- Latches the winning interrupt level and freezes the priority resolver across the acknowledge. Issues the IRR-clear and ISR-set pulses, and drives the vector byte onto the data bus on the second pulse.
- The vector byte is driven only when Address_Write_Enable from the cascade stage allows it. Optionally applies automatic EOI (AEOI) at the end of the cycle.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising INTA_N into clk (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- INTA_N  input  1  CPU interrupt-acknowledge strobe, active low, asynchronous to clk.
- Interrupt_Location  input  3  highest-priority pending level from the priority resolver.
- interruptExists  input  1  1 when an unmasked request is pending.
- Address_Write_Enable  input  1  from the cascade stage; 1 when this device owns the vector byte.
- ICW2_Vector  input  5  vector base T7..T3 from ICW2.
- AEOI  input  1  ICW4 automatic-EOI mode.
- Data_Out  output  8  vector byte.
- Data_Out_En  output  1  data-bus drive enable.
- Freeze  output  1  holds the priority resolver and IRR sampling during acknowledge.
- IRR_Clear  output  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit.
- ISR_Set  output  8  one-hot, one-cycle pulse setting the ISR bit.
- ISR_Clear  output  8  one-hot, one-cycle AEOI pulse clearing the ISR bit.
- Ack_Busy  output  1  1 whenever state is not IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE; synchroniser flops go to 1.
  - Latched level goes to 3'b111; latched valid goes to 0.
  - All outputs go to 0, including Data_Out=8'h00.
- INTA_N passes through SYNC_STAGES flops. Edge detection compares the last two synchronised samples:
  - fall = prev 1 and now 0; rise = prev 0 and now 1.
  - Response appears SYNC_STAGES+1 cycles after the pad edge.
- States: IDLE, ACK1, GAP, ACK2.
- IDLE on fall goes to ACK1, and in the same cycle:
  - latch L = interruptExists ? Interrupt_Location : 3'b111; latch V = interruptExists;
  - if V, pulse IRR_Clear[L] and ISR_Set[L] for exactly one cycle;
  - if not V (spurious), no pulses, but the cycle proceeds with level 7.
- ACK1 on rise goes to GAP. A fall seen in ACK1 is impossible and is ignored.
- GAP on fall goes to ACK2.
- ACK2 on rise goes to IDLE. In that cycle, if AEOI and V, pulse ISR_Clear[L] for one cycle.
- Freeze = 1 in ACK1, GAP and ACK2; it deasserts on the cycle the state returns to IDLE.
- Data_Out = {ICW2_Vector, L}, registered on entry to ACK2 and held through ACK2. It is 8'h00 in all other states.
- Data_Out_En = (state==ACK2) & Address_Write_Enable.
  - Combinational on Address_Write_Enable, so a slave only drives once CAS selects it.
- L and V do not change between ACK1 entry and the return to IDLE. Changes on Interrupt_Location or interruptExists are ignored while Freeze=1.
- ICW2_Vector is sampled at ACK2 entry only.
- No timeout: GAP waits indefinitely for the second pulse.
- Reset asserted mid-cycle (any state): immediate return to IDLE with all outputs 0. No partial ISR_Clear is issued, and the ISR bit already set stays set (owned by the ISR register).
- Only one of IRR_Clear/ISR_Set or ISR_Clear can be non-zero in any cycle, and each is one-hot or all-zero.

Decomposition:
- Shared package (pic_pkg):
  - state encoding constants for IDLE/ACK1/GAP/ACK2;
  - SPURIOUS_LEVEL = 3'b111;
  - a function for 3-to-8 one-hot decode.
- One natural sub-module: pic_sync_edge. It is the SYNC_STAGES synchroniser plus rise/fall detect, with reset value 1, and is reusable for RD_N/WR_N.

Test Plan:
- Normal acknowledge: interruptExists=1, Interrupt_Location=3, ICW2_Vector=5'b00001, AEOI=0, Address_Write_Enable=1, two INTA pulses.
  -> IRR_Clear=ISR_Set=8'h08 for one cycle after the first fall.
  -> Data_Out=8'h0B and Data_Out_En=1 during the second pulse.
  -> ISR_Clear stays 0; Freeze drops after the second rise.
- AEOI: same stimulus with AEOI=1 -> ISR_Clear=8'h08 for exactly one cycle, SYNC_STAGES+1 cycles after the second INTA_N rise.
- Spurious: interruptExists=0 at the first fall, ICW2_Vector=5'b01000.
  -> IRR_Clear/ISR_Set stay 0; Data_Out=8'h47 in ACK2.
  -> With AEOI=1, ISR_Clear stays 0.
- Cascade master with slave on IR3: Address_Write_Enable=0 through ACK2.
  -> ISR_Set=8'h08, Data_Out_En=0 throughout, Data_Out=8'h0B internally.
- Freeze stability: change Interrupt_Location 3 to 1 during GAP.
  -> Data_Out still 8'h0B; no further IRR_Clear/ISR_Set pulses.
- Reset mid-cycle: assert reset_n=0 in GAP with AEOI=1.
  -> Outputs 0 immediately.
  -> After release, a new two-pulse cycle with level 5 and ICW2_Vector=5'b00001 yields Data_Out=8'h0D and ISR_Clear=8'h20 only.

Source files
------------

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types, constants and helpers for the 8259A acknowledge path
package pic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_GAP  = 2'd2,
        ST_ACK2 = 2'd3
    } ack_state_t;

    // Level reported on a spurious acknowledge (no request pending at first fall).
    localparam logic [2:0] SPURIOUS_LEVEL = 3'b111;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'h01 << idx;
    endfunction

endpackage

// File: rtl/pic_sync_edge.sv
// rtl/pic_sync_edge.sv - multi-flop synchroniser with rise/fall detect for active-low strobes
//   clk, reset_n : clock, asynchronous active-low reset (all flops reset to 1)
//   din          : asynchronous strobe input
//   rise, fall   : one-cycle pulses from the last two synchronised samples
module pic_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Edge seen one cycle after the synchroniser output settles, so the
    // sequencer reacts SYNC_STAGES+1 cycles after the pad edge.
    assign fall = prev_q & ~sync_q[SYNC_STAGES-1];
    assign rise = ~prev_q & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// rtl/interrupt_ack_sequencer.sv - two-pulse 8086-mode INTA sequencer for the 8259A core
//   INTA_N                         : CPU acknowledge strobe (async, active low)
//   Interrupt_Location/interruptExists : winning level from the priority resolver
//   Address_Write_Enable           : cascade stage grants the vector byte to this device
//   ICW2_Vector, AEOI              : vector base and automatic-EOI mode
//   Data_Out/Data_Out_En           : vector byte and bus drive enable
//   Freeze, Ack_Busy               : resolver hold and sequencer activity
//   IRR_Clear/ISR_Set/ISR_Clear    : one-hot single-cycle register update pulses
module interrupt_ack_sequencer
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       INTA_N,
    input  logic [2:0] Interrupt_Location,
    input  logic       interruptExists,
    input  logic       Address_Write_Enable,
    input  logic [4:0] ICW2_Vector,
    input  logic       AEOI,
    output logic [7:0] Data_Out,
    output logic       Data_Out_En,
    output logic       Freeze,
    output logic [7:0] IRR_Clear,
    output logic [7:0] ISR_Set,
    output logic [7:0] ISR_Clear,
    output logic       Ack_Busy
);

    logic inta_rise, inta_fall;

    pic_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inta_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (INTA_N),
        .rise    (inta_rise),
        .fall    (inta_fall)
    );

    ack_state_t state_q, state_d;
    logic [2:0] level_q, level_d;
    logic       valid_q, valid_d;
    logic [7:0] irr_clear_q, irr_clear_d;
    logic [7:0] isr_set_q, isr_set_d;
    logic [7:0] isr_clear_q, isr_clear_d;
    logic [7:0] data_out_q, data_out_d;
    logic       freeze_q, freeze_d;

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        valid_d     = valid_q;
        irr_clear_d = 8'h00;
        isr_set_d   = 8'h00;
        isr_clear_d = 8'h00;
        data_out_d  = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (inta_fall) begin
                    state_d = ST_ACK1;
                    level_d = interruptExists ? Interrupt_Location : SPURIOUS_LEVEL;
                    valid_d = interruptExists;
                    if (interruptExists) begin
                        irr_clear_d = onehot8(Interrupt_Location);
                        isr_set_d   = onehot8(Interrupt_Location);
                    end
                end
            end
            ST_ACK1: begin
                if (inta_rise) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // No timeout: the second pulse may arrive arbitrarily late.
                if (inta_fall) begin
                    state_d    = ST_ACK2;
                    data_out_d = {ICW2_Vector, level_q};
                end
            end
            ST_ACK2: begin
                if (inta_rise) begin
                    state_d = ST_IDLE;
                    if (AEOI && valid_q) begin
                        isr_clear_d = onehot8(level_q);
                    end
                end else begin
                    data_out_d = data_out_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        freeze_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            level_q     <= SPURIOUS_LEVEL;
            valid_q     <= 1'b0;
            irr_clear_q <= 8'h00;
            isr_set_q   <= 8'h00;
            isr_clear_q <= 8'h00;
            data_out_q  <= 8'h00;
            freeze_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            valid_q     <= valid_d;
            irr_clear_q <= irr_clear_d;
            isr_set_q   <= isr_set_d;
            isr_clear_q <= isr_clear_d;
            data_out_q  <= data_out_d;
            freeze_q    <= freeze_d;
        end
    end

    assign Data_Out    = data_out_q;
    // A cascaded slave only drives once CAS selects it, hence combinational.
    assign Data_Out_En = (state_q == ST_ACK2) & Address_Write_Enable;
    assign Freeze      = freeze_q;
    assign IRR_Clear   = irr_clear_q;
    assign ISR_Set     = isr_set_q;
    assign ISR_Clear   = isr_clear_q;
    assign Ack_Busy    = (state_q != ST_IDLE);

endmodule
